// File: rtl/cam_analyzer_pkg.sv
// Shared codes for the camera frame analyzer: colour and figure encodings,
// controller states and the fill-ratio thresholds (eighths).
package cam_analyzer_pkg;

    typedef enum logic [1:0] {
        COL_NONE  = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        FIG_NONE = 2'd0,
        FIG_TRI  = 2'd1,
        FIG_CIRC = 2'd2,
        FIG_SQR  = 2'd3
    } figure_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_AREA   = 3'd3,
        ST_DECIDE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Fill ratio thresholds expressed as NUM/8 of the bounding-box area.
    localparam int unsigned FILL_DEN_SHIFT = 3;
    localparam int unsigned FILL_SQR_NUM   = 7;
    localparam int unsigned FILL_CIRC_NUM  = 5;

endpackage

// File: rtl/cam_frame_analyzer_pixel_classifier.sv
// Per-pixel dominant-colour classifier: splits {R,G,B}, compares each channel
// against the other two plus a margin, and registers the class with a valid flag.
module pixel_classifier
    import cam_analyzer_pkg::*;
#(
    parameter int CH_BITS = 4,
    parameter int DW      = 12,
    parameter int MARGIN  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix,
    input  logic          valid,
    output logic [1:0]    cls,
    output logic          cls_valid
);

    localparam logic [CH_BITS:0] MARGIN_E = (CH_BITS+1)'(MARGIN);

    logic [CH_BITS:0] r_s, g_s, b_s;
    logic [CH_BITS:0] r_m_s, g_m_s, b_m_s;
    color_e           cls_s;

    assign r_s   = {1'b0, pix[3*CH_BITS-1 -: CH_BITS]};
    assign g_s   = {1'b0, pix[2*CH_BITS-1 -: CH_BITS]};
    assign b_s   = {1'b0, pix[CH_BITS-1:0]};
    // One extra bit keeps channel+margin from wrapping.
    assign r_m_s = r_s + MARGIN_E;
    assign g_m_s = g_s + MARGIN_E;
    assign b_m_s = b_s + MARGIN_E;

    // Margin comparison selecting at most one dominant channel.
    always_comb begin
        cls_s = COL_NONE;
        if (r_s > g_m_s && r_s > b_m_s) begin
            cls_s = COL_RED;
        end else if (g_s > r_m_s && g_s > b_m_s) begin
            cls_s = COL_GREEN;
        end else if (b_s > r_m_s && b_s > g_m_s) begin
            cls_s = COL_BLUE;
        end else begin
            cls_s = COL_NONE;
        end
    end

    // Registered classification result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls       <= 2'd0;
            cls_valid <= 1'b0;
        end else begin
            cls       <= cls_s;
            cls_valid <= valid;
        end
    end

endmodule

// File: rtl/cam_frame_analyzer.sv
// Camera frame analyzer: scans the frame buffer, accumulates colour counts and a
// bounding box, then classifies the figure. Optional window: CAM_FRAME_ANALYZER_ROI_EN.
module cam_frame_analyzer
    import cam_analyzer_pkg::*;
#(
    parameter int FRAME_W = 160,
    parameter int FRAME_H = 120,
    parameter int AW      = 15,
    parameter int CH_BITS = 4,
    parameter int DW      = 12,
    parameter int MARGIN  = 3,
    parameter int MIN_PIX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
`ifdef CAM_FRAME_ANALYZER_ROI_EN
    input  logic [9:0]    roi_x0,
    input  logic [9:0]    roi_x1,
    input  logic [9:0]    roi_y0,
    input  logic [9:0]    roi_y1,
`endif
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    color,
    output logic [1:0]    figure,
    output logic [AW-1:0] pix_count
);

    localparam int              CW      = 2*AW + 3;
    localparam logic [AW-1:0]   ZERO_A  = {AW{1'b0}};
    localparam logic [AW-1:0]   ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   CNT_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]   FW_A    = AW'(FRAME_W);
    localparam logic [AW-1:0]   XMAX_A  = AW'(FRAME_W - 1);
    localparam logic [AW-1:0]   YMAX_A  = AW'(FRAME_H - 1);
    localparam logic [AW-1:0]   MIN_A   = AW'(MIN_PIX);
    localparam logic [CW-1:0]   SQR_K   = CW'(FILL_SQR_NUM);
    localparam logic [CW-1:0]   CIRC_K  = CW'(FILL_CIRC_NUM);

    state_e          state_r;
    logic            accept_s;
    logic            scan_last_s;
    logic [AW-1:0]   x_r, y_r, nx_s, ny_s;
    logic [AW-1:0]   x1_r, y1_r, x2_r, y2_r;
    logic            v1_r;
    logic [1:0]      cls_s;
    logic            cls_valid_s;
    logic [AW-1:0]   cnt_red_r, cnt_green_r, cnt_blue_r;
    logic [AW-1:0]   xmin_r, xmax_r, ymin_r, ymax_r;
    color_e          dom_col_s, dom_col_r;
    logic [AW-1:0]   dom_cnt_s, dom_cnt_r;
    logic [AW-1:0]   dx_s, dy_s;
    logic [2*AW-1:0] area_s, area_r;
    logic [CW-1:0]   fill_lhs_s, sqr_rhs_s, circ_rhs_s;
    figure_e         fig_s;
    logic [AW-1:0]   win_x0_s, win_x1_s, win_y0_s, win_y1_s;
    logic [AW-1:0]   start_x_s, start_y_s;
    logic            win_empty_s;

`ifdef CAM_FRAME_ANALYZER_ROI_EN
    logic [AW-1:0]   roi_x0_r, roi_x1_r, roi_y0_r, roi_y1_r;

    assign start_x_s   = AW'(roi_x0);
    assign start_y_s   = AW'(roi_y0);
    assign win_empty_s = (roi_x1 < roi_x0) || (roi_y1 < roi_y0);
    assign win_x0_s    = roi_x0_r;
    assign win_x1_s    = roi_x1_r;
    assign win_y0_s    = roi_y0_r;
    assign win_y1_s    = roi_y1_r;

    // Window bounds are captured once per frame at init acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            roi_x0_r <= ZERO_A;
            roi_x1_r <= ZERO_A;
            roi_y0_r <= ZERO_A;
            roi_y1_r <= ZERO_A;
        end else if (accept_s) begin
            roi_x0_r <= AW'(roi_x0);
            roi_x1_r <= AW'(roi_x1);
            roi_y0_r <= AW'(roi_y0);
            roi_y1_r <= AW'(roi_y1);
        end
    end
`else
    assign start_x_s   = ZERO_A;
    assign start_y_s   = ZERO_A;
    assign win_empty_s = 1'b0;
    assign win_x0_s    = ZERO_A;
    assign win_x1_s    = XMAX_A;
    assign win_y0_s    = ZERO_A;
    assign win_y1_s    = YMAX_A;
`endif

    assign accept_s    = init && (state_r == ST_IDLE || state_r == ST_DONE);
    assign scan_last_s = (x_r == win_x1_s) && (y_r == win_y1_s);

    // Raster-order successor of the current scan coordinate.
    always_comb begin
        nx_s = x_r;
        ny_s = y_r;
        if (x_r == win_x1_s) begin
            nx_s = win_x0_s;
            ny_s = y_r + ONE_A;
        end else begin
            nx_s = x_r + ONE_A;
            ny_s = y_r;
        end
    end

    // Coordinates and valid follow the read data through memory and classifier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r <= 1'b0;
            x1_r <= ZERO_A;
            y1_r <= ZERO_A;
            x2_r <= ZERO_A;
            y2_r <= ZERO_A;
        end else begin
            v1_r <= (state_r == ST_SCAN);
            x1_r <= x_r;
            y1_r <= y_r;
            x2_r <= x1_r;
            y2_r <= y1_r;
        end
    end

    pixel_classifier #(
        .CH_BITS (CH_BITS),
        .DW      (DW),
        .MARGIN  (MARGIN)
    ) u_classifier (
        .clk       (clk),
        .rst       (rst),
        .pix       (mem_data),
        .valid     (v1_r),
        .cls       (cls_s),
        .cls_valid (cls_valid_s)
    );

    // Per-colour saturating counters and the shared bounding box.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_red_r   <= ZERO_A;
            cnt_green_r <= ZERO_A;
            cnt_blue_r  <= ZERO_A;
            xmin_r      <= XMAX_A;
            ymin_r      <= YMAX_A;
            xmax_r      <= ZERO_A;
            ymax_r      <= ZERO_A;
        end else if (accept_s) begin
            cnt_red_r   <= ZERO_A;
            cnt_green_r <= ZERO_A;
            cnt_blue_r  <= ZERO_A;
            xmin_r      <= XMAX_A;
            ymin_r      <= YMAX_A;
            xmax_r      <= ZERO_A;
            ymax_r      <= ZERO_A;
        end else if (cls_valid_s && cls_s != COL_NONE) begin
            case (cls_s)
                COL_RED:   cnt_red_r   <= (cnt_red_r   == CNT_MAX) ? cnt_red_r   : cnt_red_r   + ONE_A;
                COL_GREEN: cnt_green_r <= (cnt_green_r == CNT_MAX) ? cnt_green_r : cnt_green_r + ONE_A;
                COL_BLUE:  cnt_blue_r  <= (cnt_blue_r  == CNT_MAX) ? cnt_blue_r  : cnt_blue_r  + ONE_A;
                default:   cnt_red_r   <= cnt_red_r;
            endcase
            if (x2_r < xmin_r) xmin_r <= x2_r;
            if (x2_r > xmax_r) xmax_r <= x2_r;
            if (y2_r < ymin_r) ymin_r <= y2_r;
            if (y2_r > ymax_r) ymax_r <= y2_r;
        end
    end

    // Dominant colour (ties favour red, then green) and bounding-box area.
    always_comb begin
        dom_col_s = COL_RED;
        dom_cnt_s = cnt_red_r;
        if (cnt_red_r >= cnt_green_r && cnt_red_r >= cnt_blue_r) begin
            dom_col_s = COL_RED;
            dom_cnt_s = cnt_red_r;
        end else if (cnt_green_r >= cnt_blue_r) begin
            dom_col_s = COL_GREEN;
            dom_cnt_s = cnt_green_r;
        end else begin
            dom_col_s = COL_BLUE;
            dom_cnt_s = cnt_blue_r;
        end
        dx_s   = xmax_r - xmin_r + ONE_A;
        dy_s   = ymax_r - ymin_r + ONE_A;
        area_s = {{AW{1'b0}}, dx_s} * {{AW{1'b0}}, dy_s};
    end

    // Fill-ratio classification: 8*count against 7*area and 5*area.
    always_comb begin
        fill_lhs_s = CW'(dom_cnt_r) << FILL_DEN_SHIFT;
        sqr_rhs_s  = CW'(area_r) * SQR_K;
        circ_rhs_s = CW'(area_r) * CIRC_K;
        fig_s      = FIG_TRI;
        if (fill_lhs_s >= sqr_rhs_s) begin
            fig_s = FIG_SQR;
        end else if (fill_lhs_s >= circ_rhs_s) begin
            fig_s = FIG_CIRC;
        end else begin
            fig_s = FIG_TRI;
        end
    end

    // Control FSM with registered address, status and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            x_r       <= ZERO_A;
            y_r       <= ZERO_A;
            mem_addr  <= ZERO_A;
            busy      <= 1'b0;
            done      <= 1'b0;
            color     <= 2'd0;
            figure    <= 2'd0;
            pix_count <= ZERO_A;
            dom_col_r <= COL_NONE;
            dom_cnt_r <= ZERO_A;
            area_r    <= {(2*AW){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        dom_cnt_r <= ZERO_A;
                        x_r       <= start_x_s;
                        y_r       <= start_y_s;
                        if (win_empty_s) begin
                            state_r <= ST_DECIDE;
                        end else begin
                            mem_addr <= start_y_s * FW_A + start_x_s;
                            state_r  <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (scan_last_s) begin
                        mem_addr <= ZERO_A;
                        state_r  <= ST_DRAIN;
                    end else begin
                        x_r      <= nx_s;
                        y_r      <= ny_s;
                        mem_addr <= ny_s * FW_A + nx_s;
                    end
                end
                // Leave once the last read word has entered the classifier.
                ST_DRAIN: begin
                    if (!v1_r) state_r <= ST_AREA;
                end
                ST_AREA: begin
                    dom_col_r <= dom_col_s;
                    dom_cnt_r <= dom_cnt_s;
                    area_r    <= area_s;
                    state_r   <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    pix_count <= dom_cnt_r;
                    if (dom_cnt_r < MIN_A) begin
                        color  <= COL_NONE;
                        figure <= FIG_NONE;
                    end else begin
                        color  <= dom_col_r;
                        figure <= fig_s;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_addr <= ZERO_A;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_analyzer.sv
// Directed, table-driven bench for cam_frame_analyzer with a behavioural
// synchronous-read frame buffer generating test images procedurally.
module tb_cam_frame_analyzer;

    localparam int FW = 160;
    localparam int FH = 120;
    localparam int AW = 15;
    localparam int DW = 12;
    localparam int N  = FW * FH;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy, done;
    logic [1:0]    color, figure;
    logic [AW-1:0] pix_count;
`ifdef CAM_FRAME_ANALYZER_ROI_EN
    logic [9:0]    roi_x0, roi_x1, roi_y0, roi_y1;
`endif

    int pat;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int pat;
        int col;
        int fig;
        int pix;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    cam_frame_analyzer dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
`ifdef CAM_FRAME_ANALYZER_ROI_EN
        .roi_x0    (roi_x0),
        .roi_x1    (roi_x1),
        .roi_y0    (roi_y0),
        .roi_y1    (roi_y1),
`endif
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .color     (color),
        .figure    (figure),
        .pix_count (pix_count)
    );

    // Test images indexed by pattern number.
    function automatic logic [11:0] pix_of(input int p, input int a);
        int x, y, dx, dy, tx, ty;
        logic [11:0] v;
        x  = a % FW;
        y  = a / FW;
        dx = x - 80;
        dy = y - 60;
        tx = x - 20;
        ty = y - 40;
        v  = 12'h000;
        case (p)
            1: if (x >= 10 && x <= 29 && y >= 10 && y <= 29) v = 12'hF00;
            2: if (dx*dx + dy*dy <= 225) v = 12'h0F0;
            3: if (tx >= 0 && ty >= 0 && ty < 30 && tx <= ty) v = 12'h00F;
            4: begin
                if (tx >= 0 && ty >= 0 && ty < 30 && tx <= ty) v = 12'h00F;
                else if (tx >= 0 && tx < 30 && (ty == 0 || (ty == 1 && tx <= 12))) v = 12'hF00;
            end
            5: if (x < 40 && y == 5) v = 12'hF00;
            6: v = (x >= 10 && x <= 29 && y >= 10 && y <= 29) ? 12'h510 : 12'h410;
            7: if (y < 10 && x < 20) v = (x < 10) ? 12'hF00 : 12'h0F0;
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    always @(posedge clk) mem_data <= pix_of(pat, int'(mem_addr));

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accept one init, optionally pulse a second one mid-scan, wait for done.
    task automatic run_frame(input int p, input int mid_at, output int lat, output int bcyc);
        pat = p;
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        lat  = 0;
        bcyc = busy ? 1 : 0;
        while (!done && lat < N + 64) begin
            if (lat == mid_at) init = 1'b1;
            @(posedge clk);
            #1;
            init = 1'b0;
            lat++;
            if (busy) bcyc++;
        end
    endtask

    initial begin
        int lat, bc, k;
        vecs[0] = '{0, 0, 0, 0};
        vecs[1] = '{1, 1, 3, 400};
        vecs[2] = '{2, 2, 2, 709};
        vecs[3] = '{3, 3, 1, 465};
        vecs[4] = '{4, 3, 1, 465};
        vecs[5] = '{5, 0, 0, 40};
        vecs[6] = '{6, 1, 3, 400};
        vecs[7] = '{7, 1, 1, 100};

        rst  = 1'b0;
        init = 1'b0;
        pat  = 0;
`ifdef CAM_FRAME_ANALYZER_ROI_EN
        roi_x0 = 10'd0;
        roi_x1 = 10'd159;
        roi_y0 = 10'd0;
        roi_y1 = 10'd119;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_color", int'(color), 0);
        check("rst_pixcount", int'(pix_count), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].pat, -1, lat, bc);
            check($sformatf("v%0d_latency", i), lat, N + 4);
            check($sformatf("v%0d_busy_cycles", i), bc, N + 4);
            check($sformatf("v%0d_color", i), int'(color), vecs[i].col);
            check($sformatf("v%0d_figure", i), int'(figure), vecs[i].fig);
            check($sformatf("v%0d_pixcount", i), int'(pix_count), vecs[i].pix);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_done_hold", i), int'(done), 1);
            check($sformatf("v%0d_color_hold", i), int'(color), vecs[i].col);
            check($sformatf("v%0d_addr_idle", i), int'(mem_addr), 0);
        end

        // A second init during SCAN must not restart or shorten the frame.
        run_frame(2, 100, lat, bc);
        check("midinit_latency", lat, N + 4);
        check("midinit_color", int'(color), 2);
        check("midinit_pixcount", int'(pix_count), 709);

        // Reset in the middle of a scan clears everything at once.
        pat = 1;
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        k = 0;
        while (int'(mem_addr) != 5000 && k < N) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("midrst_reach_addr", int'(mem_addr), 5000);
        rst = 1'b0;
        #1;
        check("midrst_addr", int'(mem_addr), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_color", int'(color), 0);
        check("midrst_figure", int'(figure), 0);
        check("midrst_pixcount", int'(pix_count), 0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(1, -1, lat, bc);
        check("postrst_latency", lat, N + 4);
        check("postrst_color", int'(color), 1);
        check("postrst_figure", int'(figure), 3);
        check("postrst_pixcount", int'(pix_count), 400);

`ifdef CAM_FRAME_ANALYZER_ROI_EN
        roi_x0 = 10'd10;
        roi_x1 = 10'd29;
        roi_y0 = 10'd10;
        roi_y1 = 10'd29;
        run_frame(1, -1, lat, bc);
        check("roi_latency", lat, 404);
        check("roi_color", int'(color), 1);
        check("roi_figure", int'(figure), 3);
        check("roi_pixcount", int'(pix_count), 400);
        roi_x0 = 10'd29;
        roi_x1 = 10'd10;
        run_frame(1, -1, lat, bc);
        check("roi_empty_fast", int'(lat <= 3), 1);
        check("roi_empty_color", int'(color), 0);
        check("roi_empty_figure", int'(figure), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_frame_analyzer.md
Name: cam_frame_analyzer

Overview:
Parametrised successor to the current colour/figure processing stage. On `init` it scans a stored camera frame through a synchronous read port of the frame buffer. Per pixel it classifies colour (red/green/blue/none), accumulates per-colour counts and a bounding box, then classifies the figure by fill ratio. Results go to the memory-map registers (`color`, `figure`, `done`). Frame size, pixel width and thresholds are parameters.

Parameters:
FRAME_W, 160, frame width in pixels
FRAME_H, 120, frame height in pixels
AW, 15, frame-buffer address width; must satisfy 2^AW >= FRAME_W*FRAME_H
CH_BITS, 4, bits per colour channel (4 = RGB444, 5 = RGB555)
DW, 12, pixel width; must equal 3*CH_BITS, packed {R,G,B}
MARGIN, 3, amount by which a channel must exceed both others to dominate
MIN_PIX, 64, minimum dominant-colour count for a valid detection

Ports:
clk  in  1  system clock (100 MHz); frame-buffer read port is on the same clock
rst  in  1  asynchronous, active-low reset
init  in  1  start request, sampled high in IDLE or DONE
mem_addr  out  AW  frame-buffer read address; row-major, y*FRAME_W+x
mem_data  in  DW  frame-buffer data; valid one cycle after mem_addr
busy  out  1  high from accepted init until results are registered
done  out  1  high after results are registered; cleared by next accepted init
color  out  2  0 none, 1 red, 2 green, 3 blue
figure  out  2  0 none, 1 triangle, 2 circle, 3 square
pix_count  out  AW  count of dominant-colour pixels

Behaviour:
- Reset (async assert, sync release): state IDLE. `mem_addr`, `busy`, `done`, `color`, `figure` and `pix_count` are 0. All accumulators are cleared.
- FSM states: IDLE, SCAN, DRAIN, AREA, DECIDE, DONE.
- IDLE or DONE with `init`=1 -> SCAN. On this transition: clear `done`, set `busy`, clear counters, set bbox to min=max-coordinate and max=0.
- SCAN: present addresses 0..N-1 (N=FRAME_W*FRAME_H), one per cycle. Track x/y counters with wrap (x wraps at FRAME_W-1 and increments y). x, y and valid are delayed one cycle to align with `mem_data`. After address N-1 -> DRAIN.
- DRAIN: the final data word is accumulated -> AREA.
- Pixel classification (registered, one per cycle):
  - red if R > G+MARGIN and R > B+MARGIN; green and blue are defined analogously; otherwise none.
  - Sums are computed at CH_BITS+1 width; no wrap.
  - Colour-class pixels increment cnt_r, cnt_g or cnt_b (AW bits, saturating) and update the shared bbox.
- AREA: select dominant colour as the max count, ties resolved red > green > blue. Compute area = (xmax-xmin+1)*(ymax-ymin+1), registered at 2*AW width.
- DECIDE: if the dominant count < MIN_PIX, then color=0, figure=0, pix_count=dominant count. Otherwise:
  - 8*count >= 7*area -> square
  - else 8*count >= 5*area -> circle
  - else triangle
  - Comparisons use 2*AW+3 bit width.
  - Register outputs, drop `busy`, raise `done` -> DONE.
- Latency: with init accepted at edge 0, `done` is high after edge N+4. `mem_addr` holds 0 outside SCAN.
- `init` while busy: ignored.
- Outputs stay stable in DONE until the next accepted init.
- Reset mid-scan: immediate return to IDLE with all outputs 0; a partial frame never produces results.

Optional Feature:
- Macro: CAM_FRAME_ANALYZER_ROI_EN.
- Defined: adds input ports `roi_x0`, `roi_x1` (10 bits) and `roi_y0`, `roi_y1` (10 bits), sampled on init accept.
  - SCAN visits only addresses inside the inclusive window, row by row; N becomes the ROI pixel count and latency shrinks accordingly.
  - An empty or inverted window (x1<x0 or y1<y0) goes straight to DONE with color=0 and figure=0, after 1 cycle in DECIDE.
- Undefined: no ports; the full frame is always scanned.

Decomposition:
- Package `cam_analyzer_pkg`:
  - colour codes (COL_NONE/RED/GREEN/BLUE)
  - figure codes (FIG_NONE/TRI/CIRC/SQR)
  - FSM state enum
  - fill thresholds (7/8, 5/8)
- Sub-module `pixel_classifier`: combinational channel split plus margin compare, registered output. It is instantiated once in the top FSM/accumulator module.

Test Plan:
- All-black 160x120 frame, init pulse -> `busy` for N+4 cycles; `done`=1 after edge 19204; color=0, figure=0, pix_count=0.
- Solid red (F00) 20x20 square at x=10..29, y=10..29 -> color=1, figure=3, pix_count=400.
- Green (0F0) disc, radius 15, centre (80,60), 709 px, bbox 31x31=961 -> color=2, figure=2, pix_count=709.
- Blue (00F) right triangle, legs 30, 465 px, bbox 900 -> color=3, figure=1. Extra: 40 red + 465 blue pixels -> blue dominant; 40-pixel red-only frame -> color=0 (below MIN_PIX).
- init pulsed mid-SCAN -> ignored, one `done` only. rst low at address 5000 -> all outputs 0 immediately; a new init gives the correct full result.
- CAM_FRAME_ANALYZER_ROI_EN with ROI (10,10)-(29,29) on the red-square frame -> 400 addresses scanned, only in-window; color=1, figure=3. ROI x1<x0 -> color=0, done within 3 cycles.
